// File: rtl/m_fifo_pkg.sv
// Shared FIFO helpers: pointer width and wrapping pointer increment.
package m_fifo_pkg;

  // Pointer width for a given depth; depth >= 2 so this is never 0.
  function automatic int f_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Explicit wrap at depth-1 so non-power-of-2 depths work.
  function automatic int unsigned f_ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/m_fifo_prog_if.sv
// Push/pop handshake bundle between FIFO and its producer/consumer.
interface m_fifo_prog_if #(parameter int WIDTH = 8);
  logic             push_enable;
  logic [WIDTH-1:0] push_data;
  logic             pop_enable;
  logic [WIDTH-1:0] pop_data;

  modport master (output push_enable, push_data, pop_enable, input pop_data);
  modport slave  (input  push_enable, push_data, pop_enable, output pop_data);
endinterface

// File: rtl/m_fifo_ptr.sv
// Wrapping pointer register 0..DEPTH-1 with synchronous clear.
module m_fifo_ptr
  import m_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = f_ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  // Clear beats increment; increment wraps explicitly at DEPTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= PW'(f_ptr_inc(32'(r_ptr), DEPTH));
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/m_fifo_prog.sv
// Show-ahead synchronous FIFO with programmable thresholds, sticky
// error flags, flush and high-water tracking.
module m_fifo_prog
  import m_fifo_pkg::*;
#(
  parameter int  WIDTH       = 8,
  parameter int  DEPTH       = 4,
  localparam int L2_DEPTH_P1 = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  m_fifo_prog_if.slave           bus,
  input  logic                   flush,
  input  logic [L2_DEPTH_P1-1:0] af_thresh,
  input  logic [L2_DEPTH_P1-1:0] ae_thresh,
  input  logic                   err_clear,
  output logic [L2_DEPTH_P1-1:0] item_count,
  output logic                   full_flag,
  output logic                   empty_flag,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow,
  output logic [L2_DEPTH_P1-1:0] peak_count
);

  localparam int PW = f_ptr_w(DEPTH);
  localparam int CW = L2_DEPTH_P1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count, r_peak, w_count_nxt;
  logic             r_ovf, r_udf;
  logic [PW-1:0]    w_wr_ptr, w_rd_ptr;
  logic             w_full, w_empty, w_push_acc, w_pop_acc, w_ovf_set, w_udf_set;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Flush swallows any concurrent push/pop; pop on full frees a slot for push.
  assign w_push_acc = bus.push_enable && (!w_full || bus.pop_enable) && !flush;
  assign w_pop_acc  = bus.pop_enable && !w_empty && !flush;
  assign w_ovf_set  = bus.push_enable && w_full && !bus.pop_enable && !flush;
  assign w_udf_set  = bus.pop_enable && w_empty && !flush;

  m_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .i_inc(w_push_acc), .i_clr(flush), .o_ptr(w_wr_ptr)
  );

  m_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .i_inc(w_pop_acc), .i_clr(flush), .o_ptr(w_rd_ptr)
  );

  // Storage is intentionally not reset; empty masking hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push_acc) r_mem[w_wr_ptr] <= bus.push_data;
  end

  // Next occupancy from accepted transfers.
  always_comb begin
    w_count_nxt = r_count;
    if (flush)                       w_count_nxt = '0;
    else if (w_push_acc && !w_pop_acc) w_count_nxt = r_count + CW'(1);
    else if (w_pop_acc && !w_push_acc) w_count_nxt = r_count - CW'(1);
  end

  // Count, high-water mark and sticky errors; a new error wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_peak  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (err_clear)                r_peak <= w_count_nxt;
      else if (w_count_nxt > r_peak) r_peak <= w_count_nxt;
      r_ovf <= w_ovf_set | (r_ovf & ~err_clear);
      r_udf <= w_udf_set | (r_udf & ~err_clear);
    end
  end

  assign bus.pop_data  = w_empty ? '0 : r_mem[w_rd_ptr];
  assign item_count    = r_count;
  assign full_flag     = w_full;
  assign empty_flag    = w_empty;
  // Thresholds 0 / >=DEPTH saturate naturally through these compares.
  assign almost_full   = (r_count >= af_thresh);
  assign almost_empty  = (r_count <= ae_thresh);
  assign overflow      = r_ovf;
  assign underflow     = r_udf;
  assign peak_count    = r_peak;

endmodule
